// File: rtl/i_signal_pkg.sv
// Shared types and constants for the i_signal pulse transmitter.
// Used by i_signal_tx and i_signal_timer.
package i_signal_pkg;

    localparam int TIMER_W  = 8;
    localparam int PEND_MAX = 15;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOW      = 2'd1,
        GUARD    = 2'd2,
        ACK_WAIT = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/i_signal_timer.sv
// Loadable 8-bit down-counter that stops at zero; zero flag for terminal count.
module i_signal_timer
    import i_signal_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic [TIMER_W-1:0] count,
    output logic               zero
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/i_signal_tx.sv
// Low-pulse transmitter with request queue, guard recovery and optional ack wait.
// Build option: define I_SIGNAL_TX_ACK_EN to wait for the far-end ack after each pulse.
//
// state    | meaning
// IDLE     | sig high, waiting for start or a queued request
// LOW      | sig driven low for LOW_CYCLES clocks
// GUARD    | sig high recovery for GUARD_CYCLES clocks, then done
// ACK_WAIT | sig high, wait for ack (min GUARD_CYCLES, max ACK_TIMEOUT)
module i_signal_tx
    import i_signal_pkg::*;
#(
    parameter int LOW_CYCLES   = 1,
    parameter int GUARD_CYCLES = 13,
    parameter int ACK_TIMEOUT  = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       ack,
    output logic       sig,
    output logic       busy,
    output logic [3:0] pending,
    output logic       done,
    output logic       overflow,
    output logic       timeout
);

    localparam logic [TIMER_W-1:0] LOW_LD   = TIMER_W'(LOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GUARD_LD = TIMER_W'(GUARD_CYCLES - 1);
    localparam logic [3:0]         PEND_TOP = 4'(PEND_MAX);

    state_t             state_q;
    state_t             state_nxt;
    logic               ready_q;
    logic               start_v;
    logic               consume;
    logic               inc;
    logic [3:0]         pending_nxt;
    logic               done_nxt;
    logic               ovf_nxt;
    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_ld_val;
    logic [TIMER_W-1:0] tmr_count;
    logic               tmr_zero;

    // Starts are ignored on the first clock after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign start_v = start & ready_q;
    assign consume = (state_q == IDLE) && (pending != 4'd0);
    assign inc     = start_v && !((state_q == IDLE) && (pending == 4'd0));

    i_signal_timer u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_ld_val),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

`ifdef I_SIGNAL_TX_ACK_EN
    localparam logic [TIMER_W-1:0] WAIT_LD = TIMER_W'(max_int(GUARD_CYCLES, ACK_TIMEOUT) - 1);
    localparam logic [TIMER_W-1:0] TOUT_K  = TIMER_W'(ACK_TIMEOUT - 1);

    logic               ack_seen_q;
    logic               ack_seen_nxt;
    logic               acked;
    logic               tout_nxt;
    logic [TIMER_W-1:0] elapsed;
`else
    logic unused_ok;
    assign unused_ok = ^{ack, tmr_count, 8'(ACK_TIMEOUT)};
    assign timeout   = 1'b0;
`endif

    always_comb begin
        state_nxt   = state_q;
        pending_nxt = pending;
        ovf_nxt     = overflow;
        done_nxt    = 1'b0;
        tmr_load    = 1'b0;
        tmr_ld_val  = LOW_LD;
`ifdef I_SIGNAL_TX_ACK_EN
        tout_nxt     = timeout;
        acked        = ack_seen_q | ack;
        elapsed      = WAIT_LD - tmr_count;
        ack_seen_nxt = 1'b0;
`endif

        // Same-cycle enqueue and dequeue cancel; a full queue drops the request.
        if (inc && !consume) begin
            if (pending == PEND_TOP) begin
                ovf_nxt = 1'b1;
            end else begin
                pending_nxt = pending + 4'd1;
            end
        end else if (consume && !inc) begin
            pending_nxt = pending - 4'd1;
        end

        case (state_q)
            IDLE: begin
                if (start_v || (pending != 4'd0)) begin
                    state_nxt  = LOW;
                    tmr_load   = 1'b1;
                    tmr_ld_val = LOW_LD;
                end
            end
            LOW: begin
                if (tmr_zero) begin
`ifdef I_SIGNAL_TX_ACK_EN
                    state_nxt  = ACK_WAIT;
                    tmr_ld_val = WAIT_LD;
`else
                    state_nxt  = GUARD;
                    tmr_ld_val = GUARD_LD;
`endif
                    tmr_load   = 1'b1;
                end
            end
            GUARD: begin
                if (tmr_zero) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
`ifdef I_SIGNAL_TX_ACK_EN
            ACK_WAIT: begin
                ack_seen_nxt = acked;
                if ((elapsed >= TOUT_K) && !acked) begin
                    tout_nxt = 1'b1;
                end
                // The timer starts at the longer of the two limits, so it never underflows here.
                if ((elapsed >= GUARD_LD) && (acked || (elapsed >= TOUT_K))) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sig      <= 1'b1;
            busy     <= 1'b0;
            pending  <= 4'd0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            sig      <= (state_nxt != LOW);
            busy     <= (state_nxt != IDLE);
            pending  <= pending_nxt;
            done     <= done_nxt;
            overflow <= ovf_nxt;
        end
    end

`ifdef I_SIGNAL_TX_ACK_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeout    <= 1'b0;
            ack_seen_q <= 1'b0;
        end else begin
            timeout    <= tout_nxt;
            ack_seen_q <= ack_seen_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_i_signal_tx.sv
// Self-checking bench for i_signal_tx: default instance (a) and a LOW=5/GUARD=20 instance (b).
module tb_i_signal_tx;

    typedef struct {
        logic       start;
        logic       sig;
        logic       busy;
        logic [3:0] pending;
        logic       done;
    } vec_t;

    logic       clock;
    logic       reset;
    logic       start_a, start_b, ack_a, ack_b;
    logic       sig_a, busy_a, done_a, overflow_a, timeout_a;
    logic       sig_b, busy_b, done_b, overflow_b, timeout_b;
    logic [3:0] pending_a, pending_b;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    i_signal_tx u_dut_a (
        .clock    (clock),
        .reset    (reset),
        .start    (start_a),
        .ack      (ack_a),
        .sig      (sig_a),
        .busy     (busy_a),
        .pending  (pending_a),
        .done     (done_a),
        .overflow (overflow_a),
        .timeout  (timeout_a)
    );

    i_signal_tx #(.LOW_CYCLES(5), .GUARD_CYCLES(20), .ACK_TIMEOUT(20)) u_dut_b (
        .clock    (clock),
        .reset    (reset),
        .start    (start_b),
        .ack      (ack_b),
        .sig      (sig_b),
        .busy     (busy_b),
        .pending  (pending_b),
        .done     (done_b),
        .overflow (overflow_b),
        .timeout  (timeout_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic sg, input logic b, input int p, input logic d);
        vec_t v;
        v.start   = s;
        v.sig     = sg;
        v.busy    = b;
        v.pending = 4'(p);
        v.done    = d;
        vecs.push_back(v);
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (!busy_a && !busy_b && pending_a == 4'd0 && pending_b == 4'd0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    // Expects reset low on entry; releases it and checks first-start timing on both instances.
    task automatic release_and_pulse();
        @(negedge clock);
        reset   = 1'b1;
        start_a = 1'b1;
        start_b = 1'b1;
        @(posedge clock); #1;
        check("rel_start_ignored", {busy_a, busy_b, sig_a, sig_b}, 4'b0011);
        @(posedge clock); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        check("rel_first_pulse", {sig_a, sig_b, busy_a, busy_b}, 4'b0011);
        for (int i = 2; i <= 5; i++) begin
            @(posedge clock); #1;
            check($sformatf("b_low_hold%0d", i), 32'(sig_b), 32'd0);
            if (i == 2) check("a_low_one_cycle", 32'(sig_a), 32'd1);
        end
        @(posedge clock); #1;
        check("b_low_end", 32'(sig_b), 32'd1);
        wait_idle("rel_idle", 200);
    endtask

    initial begin
        int pulses;
        int done_at;
        bit prev;
        bit ok;

        reset   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        ack_a   = 1'b0;
        ack_b   = 1'b0;
        #12;
        check("reset_a", {sig_a, busy_a, pending_a, done_a, overflow_a, timeout_a}, 9'b1_0_0000_000);
        check("reset_b", {sig_b, busy_b, pending_b, done_b, overflow_b, timeout_b}, 9'b1_0_0000_000);

        release_and_pulse();

`ifdef I_SIGNAL_TX_ACK_EN
        // Ack 12 clocks after sig low: guard still holds the exit to 14 clocks.
        start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        check("ack_sig_low", 32'(sig_a), 32'd0);
        done_at = 0;
        for (int j = 1; j <= 30; j++) begin
            @(posedge clock); #1;
            ack_a = (j == 12);
            if (done_a && done_at == 0) done_at = j;
        end
        check("ack_done_at", 32'(done_at), 32'd14);
        check("ack_no_timeout", 32'(timeout_a), 32'd0);
        wait_idle("ack_idle", 100);

        // No ack: ACK_WAIT runs 20 clocks, then timeout and done.
        start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        done_at = 0;
        for (int j = 1; j <= 30; j++) begin
            @(posedge clock); #1;
            if (done_a && done_at == 0) done_at = j;
        end
        check("tout_done_at", 32'(done_at), 32'd21);
        check("tout_sticky", 32'(timeout_a), 32'd1);
        wait_idle("tout_idle", 100);
        start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        check("served_after_tout", {sig_a, busy_a, timeout_a}, 3'b011);
        wait_idle("served_idle", 100);
`else
        ack_a = 1'b1;
        // Single start.
        add(1, 0, 1, 0, 0);
        for (int i = 0; i < 13; i++) add(0, 1, 1, 0, 0);
        add(0, 1, 0, 0, 1);
        add(0, 1, 0, 0, 0);
        // Three back-to-back starts, then a start in IDLE that meets a dequeue.
        add(1, 0, 1, 0, 0);
        add(1, 1, 1, 1, 0);
        add(1, 1, 1, 2, 0);
        for (int i = 0; i < 11; i++) add(0, 1, 1, 2, 0);
        add(0, 1, 0, 2, 1);
        add(1, 0, 1, 2, 0);
        for (int i = 0; i < 13; i++) add(0, 1, 1, 2, 0);
        add(0, 1, 0, 2, 1);
        add(0, 0, 1, 1, 0);
        for (int i = 0; i < 13; i++) add(0, 1, 1, 1, 0);
        add(0, 1, 0, 1, 1);
        add(0, 0, 1, 0, 0);
        for (int i = 0; i < 13; i++) add(0, 1, 1, 0, 0);
        add(0, 1, 0, 0, 1);
        add(0, 1, 0, 0, 0);

        foreach (vecs[i]) begin
            start_a = vecs[i].start;
            @(posedge clock); #1;
            check($sformatf("vec%0d", i), {sig_a, busy_a, pending_a, done_a},
                  {vecs[i].sig, vecs[i].busy, vecs[i].pending, vecs[i].done});
        end
        check("ack_ignored", 32'(timeout_a), 32'd0);
        ack_a = 1'b0;
`endif

        // Twenty starts while b is busy: queue saturates, four drops, sixteen pulses.
        wait_idle("ovf_pre_idle", 100);
        pulses  = 0;
        prev    = 1'b1;
        start_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (prev && !sig_b) pulses++;
            prev = sig_b;
        end
        start_b = 1'b0;
        check("ovf_pending", 32'(pending_b), 32'd15);
        check("ovf_flag", 32'(overflow_b), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clock); #1;
            if (prev && !sig_b) pulses++;
            prev = sig_b;
            if (!busy_b && pending_b == 4'd0) begin
                ok = 1'b1;
                break;
            end
        end
        check("ovf_drained", 32'(ok), 32'd1);
        check("ovf_pulses", 32'(pulses), 32'd16);
        check("ovf_sticky", 32'(overflow_b), 32'd1);

        // Reset in the middle of a LOW pulse with one request queued.
        @(negedge clock);
        start_b = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        start_b = 1'b0;
        @(posedge clock); #1;
        check("mid_low_state", {sig_b, busy_b, pending_b}, 6'b0_1_0001);
        #2;
        reset = 1'b0;
        #1;
        check("mid_reset_async", {sig_b, busy_b, pending_b, overflow_b}, 7'b1_0_0000_0);
        release_and_pulse();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
